mc_datapath: RTL and testbench

- Multicycle MIPS datapath that consumes the per-cycle control word from the main control FSM and returns `op` and `zero` to it.
- Holds PC, the non-architectural registers (IR, MDR, A, B, ALUOut), the 32x32 register file, the ALU and its funct decode.
- Drives a single unified memory port for both instruction fetch and data access.

---
 rtl/mc_datapath_if.sv | 35 +++
 rtl/mc_datapath.sv | 118 +++++++++++
 tb/tb_mc_datapath.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_datapath_if.sv
// Control and memory bundle between the multicycle control FSM and its datapath.
// The master side (control FSM plus the unified memory) drives the per-cycle
// control word and the memory read data. The slave side (datapath) returns the
// memory request along with op/zero.
interface mc_datapath_if;
  logic        IorD;
  logic        MemWrite;
  logic        IRWrite;
  logic        PCEn;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [1:0]  PCSrc;
  logic [1:0]  ALUOp;
  logic        RegWrite;
  logic        RegDst;
  logic        MemtoReg;
  logic [31:0] mem_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [5:0]  op;
  logic        zero;

  modport master (
    output IorD, MemWrite, IRWrite, PCEn, ALUSrcA, ALUSrcB, PCSrc, ALUOp,
           RegWrite, RegDst, MemtoReg, mem_rdata,
    input  mem_addr, mem_wdata, mem_we, op, zero
  );

  modport slave (
    input  IorD, MemWrite, IRWrite, PCEn, ALUSrcA, ALUSrcB, PCSrc, ALUOp,
           RegWrite, RegDst, MemtoReg, mem_rdata,
    output mem_addr, mem_wdata, mem_we, op, zero
  );
endinterface

// File: rtl/mc_datapath.sv
// Multicycle MIPS datapath: PC, IR/MDR/A/B/ALUOut, the 32x32 register file and
// the ALU. A single unified memory port serves both instruction fetch and data
// access. Control comes in from the FSM each cycle, and op/zero go back to it.
module mc_datapath #(
  parameter logic [31:0] RESET_PC          = 32'h0000_0000,
  parameter bit          RF_CLEAR_ON_RESET = 1'b1
) (
  input logic          clk,
  input logic          reset,
  mc_datapath_if.slave bus
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] mdr_q, a_q, b_q, aluout_q;
  logic [31:0] rf_q [32];

  logic [4:0]  rs, rt, rd, wa;
  logic [5:0]  funct;
  logic [31:0] rf_rd_a, rf_rd_b, rf_wd;
  logic [31:0] sign_imm, src_a, src_b, alu_result, jump_target, pc_next;
  logic        slt_w;

  assign rs    = ir_q[25:21];
  assign rt    = ir_q[20:16];
  assign rd    = ir_q[15:11];
  assign funct = ir_q[5:0];

  // Register 0 is hardwired to zero on read, so its storage slot is never consulted.
  assign rf_rd_a = (rs == 5'd0) ? 32'd0 : rf_q[rs];
  assign rf_rd_b = (rt == 5'd0) ? 32'd0 : rf_q[rt];
  assign wa      = bus.RegDst ? rd : rt;
  assign rf_wd   = bus.MemtoReg ? mdr_q : aluout_q;

  assign sign_imm    = {{16{ir_q[15]}}, ir_q[15:0]};
  assign src_a       = bus.ALUSrcA ? a_q : pc_q;
  assign jump_target = {pc_q[31:28], ir_q[25:0], 2'b00};
  assign slt_w       = $signed(src_a) < $signed(src_b);

  // Select the ALU's second operand.
  always_comb begin
    case (bus.ALUSrcB)
      2'b00:   src_b = b_q;
      2'b01:   src_b = 32'd4;
      2'b10:   src_b = sign_imm;
      default: src_b = {sign_imm[29:0], 2'b00};
    endcase
  end

  // ALU. Any unlisted ALUOp/funct combination falls back to add.
  always_comb begin
    alu_result = src_a + src_b;
    case (bus.ALUOp)
      2'b01: alu_result = src_a - src_b;
      2'b10: begin
        case (funct)
          6'b100010: alu_result = src_a - src_b;
          6'b100100: alu_result = src_a & src_b;
          6'b100101: alu_result = src_a | src_b;
          6'b101010: alu_result = {31'd0, slt_w};
          default:   ;
        endcase
      end
      default: ;
    endcase
  end

  // Next PC select and load enables for PC and IR.
  always_comb begin
    case (bus.PCSrc)
      2'b00:   pc_next = alu_result;
      2'b01:   pc_next = aluout_q;
      2'b10:   pc_next = jump_target;
      default: pc_next = pc_q;
    endcase
    pc_d = bus.PCEn    ? pc_next       : pc_q;
    ir_d = bus.IRWrite ? bus.mem_rdata : ir_q;
  end

  // Architectural and non-architectural registers. MDR/A/B/ALUOut reload every cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      mdr_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      aluout_q <= '0;
    end else begin
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      mdr_q    <= bus.mem_rdata;
      a_q      <= rf_rd_a;
      b_q      <= rf_rd_b;
      aluout_q <= alu_result;
    end
  end

  // Register file write. Reset suppresses any write, whether or not it clears the file.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (RF_CLEAR_ON_RESET) begin
        for (int i = 0; i < 32; i++) begin
          rf_q[i] <= '0;
        end
      end
    end else if (bus.RegWrite && (wa != 5'd0)) begin
      rf_q[wa] <= rf_wd;
    end
  end

  assign bus.mem_addr  = bus.IorD ? aluout_q : pc_q;
  assign bus.mem_wdata = b_q;
  assign bus.mem_we    = bus.MemWrite;
  assign bus.op        = ir_q[31:26];
  assign bus.zero      = (alu_result == 32'd0);

endmodule

// File: tb/tb_mc_datapath.sv
// Bench for mc_datapath. A sequence of directed instruction walks is followed by
// randomized control words. Every cycle, the outputs are compared with an
// instruction-level state model kept in this file.
module tb_mc_datapath;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk;
  logic reset;
  mc_datapath_if dp_if();

  mc_datapath #(.RESET_PC(RESET_PC), .RF_CLEAR_ON_RESET(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dp_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc_n    = 0;
  bit model_valid = 1'b0;

  // Reference state
  logic [31:0] m_pc, m_ir, m_mdr, m_a, m_b, m_aluout;
  logic [31:0] m_rf [32];
  logic [31:0] e_res;
  logic [5:0]  fn_tab [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", tag, got, exp, cyc_n);
    end
  endtask

  function automatic logic [31:0] alu_ref(input logic [1:0] aop, input logic [5:0] fn,
                                          input logic [31:0] x, input logic [31:0] y);
    if (aop == 2'b01) return x - y;
    if (aop != 2'b10) return x + y;
    case (fn)
      6'h22:   return x - y;
      6'h24:   return x & y;
      6'h25:   return x | y;
      6'h2a:   return (signed'(x) < signed'(y)) ? 32'd1 : 32'd0;
      default: return x + y;
    endcase
  endfunction

  // Settle at the falling edge, predict this cycle's outputs, and compare them.
  task automatic eval_cycle();
    logic [31:0] sa, sb, simm;
    @(negedge clk);
    simm = {{16{m_ir[15]}}, m_ir[15:0]};
    sa   = dp_if.ALUSrcA ? m_a : m_pc;
    case (dp_if.ALUSrcB)
      2'b00:   sb = m_b;
      2'b01:   sb = 32'd4;
      2'b10:   sb = simm;
      default: sb = simm << 2;
    endcase
    e_res = alu_ref(dp_if.ALUOp, m_ir[5:0], sa, sb);
    if (model_valid) begin
      check("mem_addr",  dp_if.mem_addr, dp_if.IorD ? m_aluout : m_pc);
      check("mem_wdata", dp_if.mem_wdata, m_b);
      check("mem_we",    {31'd0, dp_if.mem_we}, {31'd0, dp_if.MemWrite});
      check("op",        {26'd0, dp_if.op}, {26'd0, m_ir[31:26]});
      check("zero",      {31'd0, dp_if.zero}, {31'd0, (e_res == 32'd0)});
    end
    $display("cyc %0d rst=%b addr=%08h wdata=%08h we=%b op=%02h zero=%b",
             cyc_n, reset, dp_if.mem_addr, dp_if.mem_wdata, dp_if.mem_we, dp_if.op, dp_if.zero);
  endtask

  // Advance the model across the rising edge.
  task automatic commit();
    logic [31:0] n_pc, n_a, n_b, wd;
    logic [4:0]  wa;
    n_pc = m_pc;
    if (dp_if.PCEn) begin
      case (dp_if.PCSrc)
        2'b00:   n_pc = e_res;
        2'b01:   n_pc = m_aluout;
        2'b10:   n_pc = {m_pc[31:28], m_ir[25:0], 2'b00};
        default: n_pc = m_pc;
      endcase
    end
    n_a = m_rf[m_ir[25:21]];
    n_b = m_rf[m_ir[20:16]];
    wa  = dp_if.RegDst ? m_ir[15:11] : m_ir[20:16];
    wd  = dp_if.MemtoReg ? m_mdr : m_aluout;
    @(posedge clk);
    if (reset) begin
      m_pc = RESET_PC; m_ir = '0; m_mdr = '0; m_a = '0; m_b = '0; m_aluout = '0;
      for (int i = 0; i < 32; i++) m_rf[i] = '0;
      model_valid = 1'b1;
    end else begin
      if (dp_if.RegWrite && wa != 5'd0) m_rf[wa] = wd;
      m_pc = n_pc;
      if (dp_if.IRWrite) m_ir = dp_if.mem_rdata;
      m_mdr    = dp_if.mem_rdata;
      m_a      = n_a;
      m_b      = n_b;
      m_aluout = e_res;
    end
    cyc_n++;
    #1;
  endtask

  task automatic cyc();
    eval_cycle();
    commit();
  endtask

  task automatic idle();
    dp_if.IorD = 1'b0;  dp_if.MemWrite = 1'b0; dp_if.IRWrite = 1'b0; dp_if.PCEn = 1'b0;
    dp_if.ALUSrcA = 1'b0; dp_if.ALUSrcB = 2'b00; dp_if.PCSrc = 2'b00; dp_if.ALUOp = 2'b00;
    dp_if.RegWrite = 1'b0; dp_if.RegDst = 1'b0; dp_if.MemtoReg = 1'b0; dp_if.mem_rdata = '0;
  endtask

  task automatic fetch(input logic [31:0] instr);
    idle(); dp_if.IRWrite = 1'b1; dp_if.PCEn = 1'b1; dp_if.ALUSrcB = 2'b01; dp_if.mem_rdata = instr;
    cyc();
  endtask

  task automatic decode();
    idle(); cyc();
  endtask

  task automatic exec_i();
    idle(); dp_if.ALUSrcA = 1'b1; dp_if.ALUSrcB = 2'b10; cyc();
  endtask

  task automatic exec_r();
    idle(); dp_if.ALUSrcA = 1'b1; dp_if.ALUOp = 2'b10; cyc();
  endtask

  task automatic wb(input logic regdst, input logic memtoreg);
    idle(); dp_if.RegWrite = 1'b1; dp_if.RegDst = regdst; dp_if.MemtoReg = memtoreg; cyc();
  endtask

  task automatic set_reg(input logic [4:0] r, input logic [15:0] imm);
    fetch({6'h08, 5'd0, r, imm}); decode(); exec_i(); wb(1'b0, 1'b0);
  endtask

  task automatic load_reg(input logic [4:0] r, input logic [31:0] value);
    fetch({6'h23, 5'd0, r, 16'h0}); decode(); exec_i();
    idle(); dp_if.IorD = 1'b1; dp_if.mem_rdata = value; cyc();
    wb(1'b0, 1'b1);
  endtask

  task automatic rtype(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [5:0] fn);
    fetch({6'h00, rs, rt, rd, 5'd0, fn}); decode(); exec_r(); wb(1'b1, 1'b0);
  endtask

  // Read a register back through B onto mem_wdata.
  task automatic read_reg(input logic [4:0] r, input logic [31:0] exp, input string tag);
    fetch({6'h2b, 5'd0, r, 16'h0}); decode();
    idle(); eval_cycle(); check(tag, dp_if.mem_wdata, exp); commit();
  endtask

  initial begin
    logic [31:0] word;
    reset = 1'b1; idle(); cyc(); reset = 1'b0;
    idle(); eval_cycle();
    check("rst_pc", dp_if.mem_addr, RESET_PC);
    check("rst_op", {26'd0, dp_if.op}, 32'd0);
    commit();

    // Fetch addi $t0,$0,5, then execute it and write it back
    fetch(32'h2008_0005);
    idle(); eval_cycle();
    check("fetch_pc", dp_if.mem_addr, 32'h4);
    check("fetch_op", {26'd0, dp_if.op}, 32'h8);
    commit();
    exec_i();
    idle(); dp_if.RegWrite = 1'b1; dp_if.IorD = 1'b1; eval_cycle();
    check("addi_aluout", dp_if.mem_addr, 32'd5);
    commit();
    read_reg(5'd8, 32'd5, "addi_rf8");

    // R-type sub / slt / and / or
    set_reg(5'd9, 16'd7);
    rtype(5'd10, 5'd8, 5'd9, 6'h22);  read_reg(5'd10, 32'hFFFF_FFFE, "sub");
    rtype(5'd11, 5'd8, 5'd9, 6'h2a);  read_reg(5'd11, 32'd1, "slt_pos");
    set_reg(5'd8, 16'hFFFF); set_reg(5'd9, 16'h0001); set_reg(5'd11, 16'h00AA);
    rtype(5'd11, 5'd8, 5'd9, 6'h2a);  read_reg(5'd11, 32'd1, "slt_neg");
    rtype(5'd12, 5'd8, 5'd9, 6'h24);  read_reg(5'd12, 32'd1, "and");
    rtype(5'd12, 5'd9, 5'd0, 6'h25);  read_reg(5'd12, 32'd1, "or");

    // beq compare, then branch through ALUOut
    set_reg(5'd8, 16'd3); set_reg(5'd9, 16'd3);
    fetch({6'h04, 5'd8, 5'd9, 16'h0}); decode();
    idle(); dp_if.ALUSrcA = 1'b1; dp_if.ALUOp = 2'b01; eval_cycle();
    check("beq_zero_eq", {31'd0, dp_if.zero}, 32'd1); commit();
    set_reg(5'd9, 16'd4);
    fetch({6'h04, 5'd8, 5'd9, 16'h0}); decode();
    idle(); dp_if.ALUSrcA = 1'b1; dp_if.ALUOp = 2'b01; eval_cycle();
    check("beq_zero_ne", {31'd0, dp_if.zero}, 32'd0); commit();
    fetch({6'h08, 5'd0, 5'd0, 16'h0040}); decode(); exec_i();
    idle(); dp_if.PCSrc = 2'b01; dp_if.PCEn = 1'b1; cyc();
    idle(); eval_cycle(); check("branch_pc", dp_if.mem_addr, 32'h40); commit();

    // lw then sw at 0x100
    fetch({6'h23, 5'd0, 5'd12, 16'h0100}); decode(); exec_i();
    idle(); dp_if.IorD = 1'b1; dp_if.mem_rdata = 32'hDEAD_BEEF; eval_cycle();
    check("lw_addr", dp_if.mem_addr, 32'h100); commit();
    wb(1'b0, 1'b1);
    read_reg(5'd12, 32'hDEAD_BEEF, "lw_rf");
    fetch({6'h2b, 5'd0, 5'd12, 16'h0100}); decode(); exec_i();
    idle(); dp_if.IorD = 1'b1; dp_if.MemWrite = 1'b1; eval_cycle();
    check("sw_addr", dp_if.mem_addr, 32'h100);
    check("sw_we", {31'd0, dp_if.mem_we}, 32'd1);
    check("sw_wdata", dp_if.mem_wdata, 32'hDEAD_BEEF);
    commit();

    // Writes to $0 are discarded
    set_reg(5'd0, 16'd9);
    read_reg(5'd0, 32'd0, "r0_zero");

    // Jump from PC 0x1000_0004
    load_reg(5'd13, 32'h1000_0000);
    fetch({6'h00, 5'd13, 5'd0, 5'd0, 5'd0, 6'h20}); decode();
    idle(); dp_if.ALUSrcA = 1'b1; dp_if.PCEn = 1'b1; cyc();
    fetch({6'h02, 26'h40});
    idle(); dp_if.PCSrc = 2'b10; dp_if.PCEn = 1'b1; eval_cycle();
    check("j_pc_pre", dp_if.mem_addr, 32'h1000_0004); commit();
    idle(); eval_cycle(); check("j_pc", dp_if.mem_addr, 32'h1000_0100); commit();

    // Reset overriding a fetch in progress
    fetch(32'h2008_0005);
    idle(); reset = 1'b1; dp_if.IRWrite = 1'b1; dp_if.PCEn = 1'b1; dp_if.ALUSrcB = 2'b01;
    dp_if.mem_rdata = 32'h8C00_0000; cyc(); reset = 1'b0;
    idle(); eval_cycle();
    check("midrst_pc", dp_if.mem_addr, RESET_PC);
    check("midrst_op", {26'd0, dp_if.op}, 32'd0);
    commit();

    // Random control words against the model
    for (int i = 0; i < 400; i++) begin
      dp_if.IorD     = 1'($urandom_range(0, 1));
      dp_if.MemWrite = 1'($urandom_range(0, 1));
      dp_if.IRWrite  = 1'($urandom_range(0, 1));
      dp_if.PCEn     = 1'($urandom_range(0, 1));
      dp_if.ALUSrcA  = 1'($urandom_range(0, 1));
      dp_if.ALUSrcB  = 2'($urandom_range(0, 3));
      dp_if.PCSrc    = 2'($urandom_range(0, 3));
      dp_if.ALUOp    = 2'($urandom_range(0, 3));
      dp_if.RegWrite = 1'($urandom_range(0, 1));
      dp_if.RegDst   = 1'($urandom_range(0, 1));
      dp_if.MemtoReg = 1'($urandom_range(0, 1));
      word = $urandom;
      if ($urandom_range(0, 1) == 1) word[5:0] = fn_tab[$urandom_range(0, 4)];
      dp_if.mem_rdata = word;
      reset = ($urandom_range(0, 49) == 0);
      cyc();
    end
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
